// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory bus arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_WAIT} arb_state_t;

  typedef enum logic {OWN_IF, OWN_D} arb_owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter sharing one single-port memory bus between fetch and data.
// One transaction in flight; registered bus command and registered responses.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_kill,
  output logic                if_valid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_stall,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_wstrb,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_valid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_stall,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  arb_state_t state, state_next;
  arb_owner_t owner;
  logic       drop;
  logic       grant_d, grant_if;
  logic       resp_done;

  assign if_stall  = if_req & ~if_valid;
  assign d_stall   = d_req & ~d_valid;
  assign resp_done = (state == ARB_WAIT) && mem_rvalid;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    grant_d    = 1'b0;
    grant_if   = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        // A requester whose valid is pulsing this cycle is finishing, not asking again.
        if (d_req && !d_valid) begin
          grant_d    = 1'b1;
          state_next = ARB_REQ;
        end else if (if_req && !if_valid && !if_kill) begin
          grant_if   = 1'b1;
          state_next = ARB_REQ;
        end
      end
      ARB_REQ:  if (mem_gnt)    state_next = ARB_WAIT;
      ARB_WAIT: if (mem_rvalid) state_next = ARB_IDLE;
      default:  state_next = ARB_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ARB_IDLE;
    else        state <= state_next;
  end

  // NOTE: the rdata registers are reset too: they are architecturally visible and must read 0 out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner     <= OWN_IF;
      drop      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_wstrb <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_valid  <= 1'b0;
      d_valid   <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;

      if (grant_d) begin
        owner     <= OWN_D;
        mem_req   <= 1'b1;
        mem_we    <= d_we;
        mem_wstrb <= d_wstrb;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end else if (grant_if) begin
        owner     <= OWN_IF;
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_wstrb <= '0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
      end

      if (state == ARB_REQ && mem_gnt) mem_req <= 1'b0;

      // mem_we still holds the owner's command through WAIT, so it tells loads from stores.
      if (resp_done) begin
        if (owner == OWN_D) begin
          d_valid <= 1'b1;
          if (!mem_we) d_rdata <= mem_rdata;
        end else if (!(drop || if_kill)) begin
          if_valid <= 1'b1;
          if_rdata <= mem_rdata;
        end
        drop <= 1'b0;
      end else if (state != ARB_IDLE && owner == OWN_IF && if_kill) begin
        drop <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a bus responder model, a response scoreboard
// fed by the stimulus, and a monitor that pops and compares on every valid pulse.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_kill, if_valid, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_valid, d_stall;
  logic [3:0]  d_wstrb;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] if_q[$];
  logic [31:0] d_q[$];
  logic [31:0] bus_q[$];
  int gnt_delay = 0;
  int rv_delay  = 1;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_valid(if_valid), .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bus responder: grants after gnt_delay cycles of mem_req, answers rv_delay cycles later.
  initial begin
    int gnt_wait = 0;
    int rsp_cnt  = 0;
    logic [31:0] rsp_data = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rsp_data;
        end
      end else if (mem_req) begin
        if (gnt_wait < gnt_delay) gnt_wait++;
        else begin
          mem_gnt  = 1'b1;
          gnt_wait = 0;
          rsp_cnt  = rv_delay;
          rsp_data = (bus_q.size() > 0) ? bus_q.pop_front() : 32'hBAD0_BAD0;
        end
      end
    end
  end

  // Monitor: every response pulse must match the next expected word for that port.
  initial begin
    forever begin
      @(negedge clk);
      if (if_valid) begin
        if (if_q.size() == 0) check("if_valid spurious", if_valid, 1'b0);
        else                  check("if_rdata", if_rdata, if_q.pop_front());
      end
      if (d_valid) begin
        if (d_q.size() == 0) check("d_valid spurious", d_valid, 1'b0);
        else                 check("d_rdata", d_rdata, d_q.pop_front());
      end
    end
  end

  task automatic wait_valid(input bit is_d, input string name, output int at);
    int n = 0;
    while (!(is_d ? d_valid : if_valid) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, " arrives"}, is_d ? d_valid : if_valid, 1'b1);
    at = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0, at;
    int kill_rv[2] = '{3, 1};
    reset = 1'b0;
    if_req = 0; if_kill = 0; if_addr = '0;
    d_req = 0; d_we = 0; d_wstrb = '0; d_addr = '0; d_wdata = '0;

    // Reset values
    @(negedge clk);
    check("rst mem_req", mem_req, 1'b0);
    check("rst mem_we", mem_we, 1'b0);
    check("rst mem_wstrb", mem_wstrb, 4'h0);
    check("rst mem_addr", mem_addr, 32'h0);
    check("rst valids", {if_valid, d_valid}, 2'b00);
    check("rst rdata", if_rdata | d_rdata, 32'h0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);

    // Fetch only
    #1 if_req = 1; if_addr = 32'h8000_0000; n0 = cyc;
    bus_q.push_back(32'h0000_0013); if_q.push_back(32'h0000_0013);
    @(negedge clk);
    check("fetch stall N", if_stall, 1'b1);
    check("fetch mem_req N", mem_req, 1'b0);
    @(negedge clk);
    check("fetch mem_req N+1", mem_req, 1'b1);
    check("fetch mem_addr", mem_addr, 32'h8000_0000);
    check("fetch we/wstrb", {mem_we, mem_wstrb}, 5'b0);
    check("fetch stall N+1", if_stall, 1'b1);
    @(negedge clk);
    check("fetch stall N+2", if_stall, 1'b1);
    @(negedge clk);
    check("fetch if_valid N+3", if_valid, 1'b1);
    check("fetch stall N+3", if_stall, 1'b0);
    @(posedge clk); #1 if_req = 0;
    @(negedge clk);
    check("no refetch after valid", mem_req, 1'b0);

    // Conflict: data wins, fetch follows
    @(posedge clk); #1 n0 = cyc;
    if_req = 1; if_addr = 32'h8000_0004;
    d_req = 1; d_we = 0; d_addr = 32'h0000_1000;
    bus_q.push_back(32'hAAAA_0001); bus_q.push_back(32'h0000_0093);
    d_q.push_back(32'hAAAA_0001);   if_q.push_back(32'h0000_0093);
    @(negedge clk); @(negedge clk);
    check("conflict data first", mem_addr, 32'h0000_1000);
    @(negedge clk); @(negedge clk);
    check("conflict d_valid N+3", d_valid, 1'b1);
    check("conflict if_stall N+3", if_stall, 1'b1);
    @(posedge clk); #1 d_req = 0;
    @(negedge clk);
    check("conflict fetch mem_req N+4", mem_req, 1'b1);
    check("conflict fetch addr", mem_addr, 32'h8000_0004);
    wait_valid(1'b0, "conflict if_valid", at);
    check("conflict if_valid >= N+6", at >= n0 + 6, 1'b1);
    @(posedge clk); #1 if_req = 0;

    // Store with delayed grant
    gnt_delay = 3;
    @(posedge clk); #1
    d_req = 1; d_we = 1; d_wstrb = 4'b0011; d_addr = 32'h0000_2000; d_wdata = 32'hDEAD_BEEF;
    bus_q.push_back(32'hFFFF_FFFF); d_q.push_back(32'hAAAA_0001);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("store mem_req held", mem_req, 1'b1);
      check("store cmd stable", {mem_we, mem_wstrb}, {1'b1, 4'b0011});
      check("store addr stable", mem_addr, 32'h0000_2000);
      check("store wdata stable", mem_wdata, 32'hDEAD_BEEF);
    end
    wait_valid(1'b1, "store d_valid", at);
    @(posedge clk); #1 d_req = 0; d_we = 0; gnt_delay = 0;

    // Kill in WAIT: once before the response, once in the same cycle as it
    for (int k = 0; k < 2; k++) begin
      rv_delay = kill_rv[k];
      @(posedge clk); #1 if_req = 1; if_addr = 32'h8000_0008;
      bus_q.push_back(32'h1111_1111);
      @(posedge clk); @(posedge clk);
      #1 if_kill = 1; if_req = 0;
      @(posedge clk); #1 if_kill = 0;
      repeat (6) @(negedge clk);
      check("kill keeps if_rdata", if_rdata, 32'h0000_0093);
    end
    rv_delay = 1;

    // Kill in the request cycle: not granted
    @(posedge clk); #1 if_req = 1; if_kill = 1; if_addr = 32'h8000_000C;
    @(posedge clk); #1 if_req = 0; if_kill = 0;
    @(negedge clk);
    check("killed request not granted", mem_req, 1'b0);

    // Next fetch after kill returns normally
    @(posedge clk); #1 if_req = 1; if_addr = 32'h8000_0010;
    bus_q.push_back(32'h0000_0517); if_q.push_back(32'h0000_0517);
    @(negedge clk);
    wait_valid(1'b0, "post-kill fetch", at);
    @(posedge clk); #1 if_req = 0;

    // Reset in WAIT; the late response must be ignored
    rv_delay = 4;
    @(posedge clk); #1 if_req = 1; if_addr = 32'h8000_0020;
    bus_q.push_back(32'h2222_2222);
    @(posedge clk); @(posedge clk);
    #1 reset = 1'b0; if_req = 0;
    @(negedge clk);
    check("reset mem_req", mem_req, 1'b0);
    check("reset mem_addr", mem_addr, 32'h0);
    check("reset if_rdata", if_rdata, 32'h0);
    check("reset d_rdata", d_rdata, 32'h0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (8) @(negedge clk);
    check("late rvalid ignored", if_rdata, 32'h0);
    check("idle after reset", mem_req, 1'b0);

    check("if scoreboard drained", if_q.size(), 0);
    check("d scoreboard drained", d_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
